// File: rtl/disp_pkg.sv
// Shared constants for the BCD display driver: segment codes, FSM encoding,
// and the largest value that fits in a given number of decimal digits.
package disp_pkg;

    // Active-low segments, bit6 = a ... bit0 = g
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        LATCH = 2'd2
    } state_t;

    function automatic logic [63:0] max_value(input int digits);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < digits; i++) p = p * 64'd10;
        return p - 64'd1;
    endfunction

endpackage

// File: rtl/bcd_display_driver_if.sv
// Load handshake and latched display outputs of the BCD display driver.
// Signal prefixes are from the driver's point of view.
interface bcd_display_driver_if #(
    parameter int DIGITS = 4,
    parameter int WIDTH  = 14
);
    logic [WIDTH-1:0]    i_num;
    logic                i_load;
    logic                o_busy;
    logic                o_done;
    logic                o_ovf;
    logic [4*DIGITS-1:0] o_bcd;
    logic [7*DIGITS-1:0] o_hex;

    modport master (
        output i_num, i_load,
        input  o_busy, o_done, o_ovf, o_bcd, o_hex
    );

    modport slave (
        input  i_num, i_load,
        output o_busy, o_done, o_ovf, o_bcd, o_hex
    );
endinterface

// File: rtl/seg7_digit.sv
// One BCD digit to active-low seven-segment decoder; dash overrides blank,
// and non-decimal codes show blank.
module seg7_digit
    import disp_pkg::*;
(
    input  logic [3:0] i_bcd,
    input  logic       i_blank,
    input  logic       i_dash,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        if (i_dash) begin
            o_seg = SEG_DASH;
        end else if (!i_blank) begin
            case (i_bcd)
                4'd0:    o_seg = SEG_0;
                4'd1:    o_seg = SEG_1;
                4'd2:    o_seg = SEG_2;
                4'd3:    o_seg = SEG_3;
                4'd4:    o_seg = SEG_4;
                4'd5:    o_seg = SEG_5;
                4'd6:    o_seg = SEG_6;
                4'd7:    o_seg = SEG_7;
                4'd8:    o_seg = SEG_8;
                4'd9:    o_seg = SEG_9;
                default: o_seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/bcd_display_driver.sv
// Serial double-dabble binary-to-BCD converter driving DIGITS seven-segment
// digits, with optional leading-zero blanking and overflow dashes.
module bcd_display_driver
    import disp_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int WIDTH    = 14,
    parameter int BLANK_LZ = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    bcd_display_driver_if.slave bus
);

    localparam int SRW  = WIDTH + 4 * DIGITS;
    localparam int CNTW = $clog2(WIDTH + 1);
    localparam int CW   = (WIDTH > 4 * DIGITS) ? WIDTH : 4 * DIGITS;
    localparam logic [CW-1:0] MAX_VAL = CW'(max_value(DIGITS));

    state_t              r_state;
    state_t              w_state_nxt;
    logic [SRW-1:0]      r_sr;
    logic [SRW-1:0]      w_sr_adj;
    logic [CNTW-1:0]     r_cnt;
    logic                r_ovf_pend;
    logic                r_busy;
    logic                r_done;
    logic                r_ovf;
    logic [4*DIGITS-1:0] r_bcd;
    logic [7*DIGITS-1:0] r_hex;

    logic [4*DIGITS-1:0] w_scratch;
    logic [DIGITS-1:0]   w_blank;
    logic [7*DIGITS-1:0] w_seg;
    logic                w_accept;
    logic                w_latch;
    logic                w_ovf_num;

    assign w_scratch = r_sr[SRW-1 -: 4*DIGITS];
    assign w_ovf_num = CW'(bus.i_num) > MAX_VAL;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_latch     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.i_load) begin
                    w_accept    = 1'b1;
                    w_state_nxt = CONV;
                end
            end
            CONV: begin
                if (r_cnt == CNTW'(1)) w_state_nxt = LATCH;
            end
            LATCH: begin
                w_latch     = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Add-3 correction on every scratch digit before the shift
    always_comb begin
        w_sr_adj = r_sr;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_sr[WIDTH+4*i +: 4] >= 4'd5)
                w_sr_adj[WIDTH+4*i +: 4] = r_sr[WIDTH+4*i +: 4] + 4'd3;
        end
    end

    // A digit blanks when it and everything above it is zero; digit 0 never does
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        w_blank    = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above & (w_scratch[4*i +: 4] == 4'd0);
            w_blank[i] = (BLANK_LZ != 0) && (i != 0) && zero_above;
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        seg7_digit u_seg (
            .i_bcd   (w_scratch[4*g +: 4]),
            .i_blank (w_blank[g]),
            .i_dash  (r_ovf_pend),
            .o_seg   (w_seg[7*g +: 7])
        );
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sr       <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ovf      <= 1'b0;
            r_bcd      <= '0;
            r_hex      <= '1;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_sr       <= SRW'(bus.i_num);
                r_cnt      <= CNTW'(WIDTH);
                r_ovf_pend <= w_ovf_num;
                r_busy     <= 1'b1;
            end else if (r_state == CONV) begin
                r_sr  <= w_sr_adj << 1;
                r_cnt <= r_cnt - CNTW'(1);
            end
            if (w_latch) begin
                r_hex  <= w_seg;
                r_bcd  <= r_ovf_pend ? '1 : w_scratch;
                r_ovf  <= r_ovf_pend;
                r_done <= 1'b1;
                r_busy <= 1'b0;
            end
        end
    end

    assign bus.o_busy = r_busy;
    assign bus.o_done = r_done;
    assign bus.o_ovf  = r_ovf;
    assign bus.o_bcd  = r_bcd;
    assign bus.o_hex  = r_hex;

endmodule

// File: tb/tb_bcd_display_driver.sv
// Directed bench for bcd_display_driver: two instances (blanking on/off)
// share the same stimulus; expected values are hand-computed.
module tb_bcd_display_driver;

    localparam logic [6:0] S0 = 7'b0000001;
    localparam logic [6:0] S1 = 7'b1001111;
    localparam logic [6:0] S2 = 7'b0010010;
    localparam logic [6:0] S3 = 7'b0000110;
    localparam logic [6:0] S4 = 7'b1001100;
    localparam logic [6:0] S5 = 7'b0100100;
    localparam logic [6:0] S6 = 7'b0100000;
    localparam logic [6:0] S7 = 7'b0001111;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0000100;
    localparam logic [6:0] SB = 7'b1111111;
    localparam logic [6:0] SD = 7'b1111110;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bcd_display_driver_if #(.DIGITS(4), .WIDTH(14)) bus ();
    bcd_display_driver_if #(.DIGITS(4), .WIDTH(14)) bus_nz ();

    assign bus_nz.i_num  = bus.i_num;
    assign bus_nz.i_load = bus.i_load;

    bcd_display_driver #(.DIGITS(4), .WIDTH(14), .BLANK_LZ(1)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    bcd_display_driver #(.DIGITS(4), .WIDTH(14), .BLANK_LZ(0)) dut_nz (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus_nz.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept a load on the next edge, then wait (bounded) for DONE
    task automatic convert(input logic [13:0] v, output int lat);
        bus.i_num  = v;
        bus.i_load = 1'b1;
        tick();
        bus.i_load = 1'b0;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (bus.o_done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        bus.i_load = 1'b0;
        bus.i_num  = '0;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (bus.o_hex !== {4{SB}}) begin
            errors++; $display("FAIL reset_hex got %h want %h", bus.o_hex, {4{SB}});
        end
        checks++;
        if (bus.o_bcd !== 16'h0000) begin
            errors++; $display("FAIL reset_bcd got %h want 0000", bus.o_bcd);
        end
        checks++;
        if ({bus.o_busy, bus.o_done, bus.o_ovf} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got %b want 000", {bus.o_busy, bus.o_done, bus.o_ovf});
        end
    endtask

    task automatic test_1234();
        int lat;
        int busy_low;
        bus.i_num  = 14'd1234;
        bus.i_load = 1'b1;
        tick();
        bus.i_load = 1'b0;
        lat = -1;
        busy_low = 0;
        for (int n = 1; n <= 40; n++) begin
            if (!bus.o_busy) busy_low++;
            tick();
            if (bus.o_done) begin
                lat = n;
                break;
            end
        end
        checks++;
        if (lat !== 15) begin
            errors++; $display("FAIL latency_1234 got %0d want 15", lat);
        end
        checks++;
        if (busy_low !== 0) begin
            errors++; $display("FAIL busy_during_conv got %0d low cycles want 0", busy_low);
        end
        checks++;
        if (bus.o_bcd !== 16'h1234) begin
            errors++; $display("FAIL bcd_1234 got %h want 1234", bus.o_bcd);
        end
        checks++;
        if (bus.o_hex !== {S1, S2, S3, S4}) begin
            errors++; $display("FAIL hex_1234 got %b want %b", bus.o_hex, {S1, S2, S3, S4});
        end
        checks++;
        if (bus.o_ovf !== 1'b0) begin
            errors++; $display("FAIL ovf_1234 got %b want 0", bus.o_ovf);
        end
        tick();
        checks++;
        if ({bus.o_busy, bus.o_done} !== 2'b00) begin
            errors++; $display("FAIL after_done got busy/done %b want 00", {bus.o_busy, bus.o_done});
        end
        checks++;
        if (bus.o_bcd !== 16'h1234) begin
            errors++; $display("FAIL bcd_hold got %h want 1234", bus.o_bcd);
        end
    endtask

    task automatic test_blanking();
        int lat;
        convert(14'd0, lat);
        checks++;
        if (bus.o_hex !== {SB, SB, SB, S0}) begin
            errors++; $display("FAIL hex_zero_blank got %b want %b", bus.o_hex, {SB, SB, SB, S0});
        end
        checks++;
        if (bus_nz.o_hex !== {S0, S0, S0, S0}) begin
            errors++; $display("FAIL hex_zero_noblank got %b want %b", bus_nz.o_hex, {S0, S0, S0, S0});
        end
        convert(14'd7, lat);
        checks++;
        if (bus_nz.o_hex !== {S0, S0, S0, S7}) begin
            errors++; $display("FAIL hex_7_noblank got %b want %b", bus_nz.o_hex, {S0, S0, S0, S7});
        end
        checks++;
        if (bus.o_hex !== {SB, SB, SB, S7}) begin
            errors++; $display("FAIL hex_7_blank got %b want %b", bus.o_hex, {SB, SB, SB, S7});
        end
        convert(14'd1000, lat);
        checks++;
        if (bus.o_hex !== {S1, S0, S0, S0}) begin
            errors++; $display("FAIL hex_1000 got %b want %b", bus.o_hex, {S1, S0, S0, S0});
        end
        convert(14'd10, lat);
        checks++;
        if (bus.o_hex !== {SB, SB, S1, S0}) begin
            errors++; $display("FAIL hex_10 got %b want %b", bus.o_hex, {SB, SB, S1, S0});
        end
        checks++;
        if (bus.o_bcd !== 16'h0010) begin
            errors++; $display("FAIL bcd_10 got %h want 0010", bus.o_bcd);
        end
    endtask

    task automatic test_overflow();
        int lat;
        convert(14'd9999, lat);
        checks++;
        if (bus.o_hex !== {S9, S9, S9, S9} || bus.o_ovf !== 1'b0 || bus.o_bcd !== 16'h9999) begin
            errors++; $display("FAIL ovf_9999 got hex %b ovf %b bcd %h want %b 0 9999",
                               bus.o_hex, bus.o_ovf, bus.o_bcd, {S9, S9, S9, S9});
        end
        convert(14'd10000, lat);
        checks++;
        if (bus.o_hex !== {SD, SD, SD, SD} || bus.o_ovf !== 1'b1 || bus.o_bcd !== 16'hFFFF) begin
            errors++; $display("FAIL ovf_10000 got hex %b ovf %b bcd %h want %b 1 ffff",
                               bus.o_hex, bus.o_ovf, bus.o_bcd, {SD, SD, SD, SD});
        end
        convert(14'd16383, lat);
        checks++;
        if (bus.o_hex !== {SD, SD, SD, SD} || bus.o_ovf !== 1'b1 || bus.o_bcd !== 16'hFFFF) begin
            errors++; $display("FAIL ovf_16383 got hex %b ovf %b bcd %h want %b 1 ffff",
                               bus.o_hex, bus.o_ovf, bus.o_bcd, {SD, SD, SD, SD});
        end
        convert(14'd5, lat);
        checks++;
        if (bus.o_ovf !== 1'b0 || bus.o_hex !== {SB, SB, SB, S5}) begin
            errors++; $display("FAIL ovf_clear got ovf %b hex %b want 0 %b", bus.o_ovf, bus.o_hex, {SB, SB, SB, S5});
        end
    endtask

    task automatic test_ignore_load();
        int dones;
        int first;
        bus.i_num  = 14'd42;
        bus.i_load = 1'b1;
        tick();
        bus.i_load = 1'b0;
        dones = 0;
        first = -1;
        for (int n = 1; n <= 40; n++) begin
            if (n == 5) begin
                bus.i_num  = 14'd77;
                bus.i_load = 1'b1;
            end
            tick();
            bus.i_load = 1'b0;
            if (bus.o_done) begin
                dones++;
                if (first < 0) first = n;
            end
        end
        checks++;
        if (dones !== 1 || first !== 15) begin
            errors++; $display("FAIL ignore_load_done got %0d dones first %0d want 1 at 15", dones, first);
        end
        checks++;
        if (bus.o_bcd !== 16'h0042) begin
            errors++; $display("FAIL ignore_load_bcd got %h want 0042", bus.o_bcd);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        int dones;
        convert(14'd1234, lat);
        bus.i_num  = 14'd5678;
        bus.i_load = 1'b1;
        tick();
        bus.i_load = 1'b0;
        for (int n = 1; n <= 7; n++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (bus.o_hex !== {4{SB}} || bus.o_busy !== 1'b0 || bus.o_done !== 1'b0) begin
            errors++; $display("FAIL rst_mid got hex %b busy %b done %b want all-ones 0 0",
                               bus.o_hex, bus.o_busy, bus.o_done);
        end
        dones = 0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (bus.o_done || bus.o_busy) dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++; $display("FAIL rst_mid_quiet got %0d active cycles want 0", dones);
        end
        convert(14'd5678, lat);
        checks++;
        if (lat !== 15 || bus.o_bcd !== 16'h5678 || bus.o_hex !== {S5, S6, S7, S8}) begin
            errors++; $display("FAIL after_rst_5678 got lat %0d bcd %h hex %b want 15 5678 %b",
                               lat, bus.o_bcd, bus.o_hex, {S5, S6, S7, S8});
        end
    endtask

    task automatic test_back_to_back();
        int done_at[$];
        int busy_low;
        bus.i_num  = 14'd100;
        bus.i_load = 1'b1;
        busy_low = 0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (bus.o_done) done_at.push_back(n);
            if (!bus.o_busy) busy_low++;
        end
        bus.i_load = 1'b0;
        checks++;
        if (done_at.size() !== 2) begin
            errors++; $display("FAIL b2b_count got %0d dones want 2", done_at.size());
        end else begin
            checks++;
            if (done_at[0] !== 16 || done_at[1] - done_at[0] !== 16) begin
                errors++; $display("FAIL b2b_spacing got %0d,%0d want 16,32", done_at[0], done_at[1]);
            end
        end
        checks++;
        if (busy_low !== 2) begin
            errors++; $display("FAIL b2b_busy_low got %0d want 2", busy_low);
        end
        for (int n = 0; n < 20; n++) tick();
        checks++;
        if (bus.o_busy !== 1'b0 || bus.o_bcd !== 16'h0100 || bus.o_hex !== {SB, S1, S0, S0}) begin
            errors++; $display("FAIL b2b_final got busy %b bcd %h hex %b want 0 0100 %b",
                               bus.o_busy, bus.o_bcd, bus.o_hex, {SB, S1, S0, S0});
        end
    endtask

    initial begin
        test_reset();
        test_1234();
        test_blanking();
        test_overflow();
        test_ignore_load();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
